// File: rtl/scale_out_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : scale_out_stage
// Purpose  : Registered FFT output scaler. Takes packed complex samples
//            {real, imag} from the last butterfly stage, optionally applies
//            an arithmetic right shift (with optional round-half-up) chosen
//            once per frame, saturates each component to OUT_WIDTH and
//            reports whether any component of the frame clipped.
// Ports    : Clk        - clock, rising edge
//            Rst_n      - asynchronous active-low reset
//            A_In       - input sample {real, imag}, signed, 2*DATA_WIDTH
//            In_Valid   - A_In valid
//            In_Ready   - stage can accept a sample
//            Swap       - 1 = scale, 0 = pass through (still saturated)
//            Shift      - right-shift amount, clamped to SHIFT_MAX
//            Round_En   - 1 = round half up, 0 = truncate
//            R_Out      - output sample {real, imag}, 2*OUT_WIDTH
//            Out_Valid  - R_Out valid
//            Out_Ready  - downstream accepts R_Out
//            Out_First  - R_Out is sample 0 of a frame
//            Out_Last   - R_Out is sample N_POINTS-1 of a frame
//            Sat_Frame  - with Out_Last: some component of the frame clipped
// Revision : 1.0 - initial release
// ============================================================================
module scale_out_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int N_POINTS   = 64,
    parameter int SHIFT_MAX  = 6,
    parameter int SHIFT_W    = 3
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [2*DATA_WIDTH-1:0] A_In,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    input  logic                    Swap,
    input  logic [SHIFT_W-1:0]      Shift,
    input  logic                    Round_En,
    output logic [2*OUT_WIDTH-1:0]  R_Out,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic                    Out_First,
    output logic                    Out_Last,
    output logic                    Sat_Frame
);

    localparam int c_CNT_W = (N_POINTS > 2) ? $clog2(N_POINTS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(N_POINTS - 1);
    localparam logic [SHIFT_W-1:0] c_SHIFT_MAX = SHIFT_W'(SHIFT_MAX);
    // Output range expressed in the internal DATA_WIDTH+1 signed domain.
    localparam logic signed [DATA_WIDTH:0] c_OUT_MAX =
        (DATA_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [DATA_WIDTH:0] c_OUT_MIN = ~c_OUT_MAX;

    // Scale and saturate one component. Returns {saturation_event, value}.
    function automatic logic [OUT_WIDTH:0] scale_sat(
        input logic [DATA_WIDTH-1:0] x,
        input logic                  scale,
        input logic [SHIFT_W-1:0]    s,
        input logic                  rnd
    );
        logic signed [DATA_WIDTH:0] v;
        logic        [DATA_WIDTH:0] addend;
        logic                       sat;
        v      = $signed({x[DATA_WIDTH-1], x});
        // 2^(s-1); the extra sign bit keeps max positive + addend in range.
        addend = ({{DATA_WIDTH{1'b0}}, 1'b1} << s) >> 1;
        sat    = 1'b0;
        if (scale && (s != '0)) begin
            if (rnd) begin
                v = v + $signed(addend);
            end
            v = v >>> s;
        end
        if (v > c_OUT_MAX) begin
            v   = c_OUT_MAX;
            sat = 1'b1;
        end else if (v < c_OUT_MIN) begin
            v   = c_OUT_MIN;
            sat = 1'b1;
        end
        return {sat, v[OUT_WIDTH-1:0]};
    endfunction

    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_cfg_swap;
    logic [SHIFT_W-1:0]     r_cfg_shift;
    logic                   r_cfg_round;
    logic                   r_sticky;
    logic [2*OUT_WIDTH-1:0] r_out_data;
    logic                   r_out_valid;
    logic                   r_out_first;
    logic                   r_out_last;
    logic                   r_sat_frame;

    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic                   w_first_in;
    logic                   w_last_in;
    logic [SHIFT_W-1:0]     w_shift_clamp;
    logic                   w_swap_eff;
    logic [SHIFT_W-1:0]     w_shift_eff;
    logic                   w_round_eff;
    logic [OUT_WIDTH:0]     w_re;
    logic [OUT_WIDTH:0]     w_im;
    logic                   w_sat_evt;

    assign In_Ready   = ~r_out_valid | Out_Ready;
    assign w_in_xfer  = In_Valid & In_Ready;
    assign w_out_xfer = r_out_valid & Out_Ready;

    assign w_first_in    = (r_cnt == '0);
    assign w_last_in     = (r_cnt == c_LAST);
    assign w_shift_clamp = (Shift > c_SHIFT_MAX) ? c_SHIFT_MAX : Shift;

    // Sample 0 of a frame uses the live config, which is latched for the rest.
    assign w_swap_eff  = w_first_in ? Swap          : r_cfg_swap;
    assign w_shift_eff = w_first_in ? w_shift_clamp : r_cfg_shift;
    assign w_round_eff = w_first_in ? Round_En      : r_cfg_round;

    assign w_re = scale_sat(A_In[2*DATA_WIDTH-1:DATA_WIDTH], w_swap_eff,
                            w_shift_eff, w_round_eff);
    assign w_im = scale_sat(A_In[DATA_WIDTH-1:0], w_swap_eff,
                            w_shift_eff, w_round_eff);
    assign w_sat_evt = w_re[OUT_WIDTH] | w_im[OUT_WIDTH];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt       <= '0;
            r_cfg_swap  <= 1'b0;
            r_cfg_shift <= '0;
            r_cfg_round <= 1'b0;
            r_sticky    <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_sat_frame <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_cnt       <= r_cnt + c_CNT_W'(1);
                r_out_data  <= {w_re[OUT_WIDTH-1:0], w_im[OUT_WIDTH-1:0]};
                r_out_valid <= 1'b1;
                r_out_first <= w_first_in;
                r_out_last  <= w_last_in;
                r_sat_frame <= w_last_in & (r_sticky | w_sat_evt);
                // Cleared on the last sample so the next frame starts clean.
                r_sticky    <= ~w_last_in & (r_sticky | w_sat_evt);
                if (w_first_in) begin
                    r_cfg_swap  <= Swap;
                    r_cfg_shift <= w_shift_clamp;
                    r_cfg_round <= Round_En;
                end
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign R_Out     = r_out_data;
    assign Out_Valid = r_out_valid;
    assign Out_First = r_out_first;
    assign Out_Last  = r_out_last;
    assign Sat_Frame = r_sat_frame;

endmodule
`default_nettype wire

// File: tb/tb_scale_out_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_scale_out_stage
// Purpose  : Self-checking bench for scale_out_stage. Two instances share
//            stimulus: 16-bit output and 10-bit output (to exercise clipping).
//            A reference model fills per-instance queues at input transfers;
//            output transfers are popped and compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scale_out_stage;

    localparam int c_N    = 64;
    localparam int c_SMAX = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_in = '0;
    logic        in_valid = 1'b0;
    logic        swap = 1'b0;
    logic [2:0]  shift = '0;
    logic        round_en = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready16, ov16, of16, ol16, sf16;
    logic [31:0] r16;
    logic        in_ready10, ov10, of10, ol10, sf10;
    logic [19:0] r10;

    always #5 clk = ~clk;

    scale_out_stage #(.DATA_WIDTH(16), .OUT_WIDTH(16), .N_POINTS(64),
                      .SHIFT_MAX(6), .SHIFT_W(3)) dut16 (
        .Clk(clk), .Rst_n(rst_n), .A_In(a_in), .In_Valid(in_valid),
        .In_Ready(in_ready16), .Swap(swap), .Shift(shift), .Round_En(round_en),
        .R_Out(r16), .Out_Valid(ov16), .Out_Ready(out_ready),
        .Out_First(of16), .Out_Last(ol16), .Sat_Frame(sf16));

    scale_out_stage #(.DATA_WIDTH(16), .OUT_WIDTH(10), .N_POINTS(64),
                      .SHIFT_MAX(6), .SHIFT_W(3)) dut10 (
        .Clk(clk), .Rst_n(rst_n), .A_In(a_in), .In_Valid(in_valid),
        .In_Ready(in_ready10), .Swap(swap), .Shift(shift), .Round_En(round_en),
        .R_Out(r10), .Out_Valid(ov10), .Out_Ready(out_ready),
        .Out_First(of10), .Out_Last(ol10), .Sat_Frame(sf10));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic        last;
        logic        sat;
    } exp_t;

    exp_t q16[$];
    exp_t q10[$];
    exp_t e16, e10;

    int m_cnt = 0;
    int m_shift = 0;
    bit m_swap = 0, m_round = 0, m_sticky16 = 0, m_sticky10 = 0;

    function automatic void model_comp(input logic [15:0] x, input bit sc, input int s,
                                       input bit rnd, input int ow,
                                       output int val, output bit sat);
        int v, mx, mn;
        v   = int'($signed(x));
        mx  = (1 << (ow - 1)) - 1;
        mn  = -(1 << (ow - 1));
        sat = 0;
        if (sc && s > 0) begin
            if (rnd) v = v + (1 << (s - 1));
            v = v >>> s;
        end
        if (v > mx) begin v = mx; sat = 1; end
        else if (v < mn) begin v = mn; sat = 1; end
        val = v;
    endfunction

    function automatic logic [31:0] pack(input int re, input int im, input int ow);
        logic [31:0] mask;
        mask = (32'd1 << ow) - 32'd1;
        return ((32'(re) & mask) << ow) | (32'(im) & mask);
    endfunction

    function automatic void model_push(input logic [31:0] a);
        exp_t e;
        int re, im;
        bit sr, si, last;
        if (m_cnt == 0) begin
            m_swap  = swap;
            m_shift = (int'(shift) > c_SMAX) ? c_SMAX : int'(shift);
            m_round = round_en;
        end
        last = (m_cnt == c_N - 1);
        model_comp(a[31:16], m_swap, m_shift, m_round, 16, re, sr);
        model_comp(a[15:0],  m_swap, m_shift, m_round, 16, im, si);
        e.data = pack(re, im, 16); e.first = (m_cnt == 0); e.last = last;
        e.sat = last & (m_sticky16 | sr | si);
        m_sticky16 = !last && (m_sticky16 || sr || si);
        q16.push_back(e);
        model_comp(a[31:16], m_swap, m_shift, m_round, 10, re, sr);
        model_comp(a[15:0],  m_swap, m_shift, m_round, 10, im, si);
        e.data = pack(re, im, 10);
        e.sat = last & (m_sticky10 | sr | si);
        m_sticky10 = !last && (m_sticky10 || sr || si);
        q10.push_back(e);
        m_cnt = (m_cnt + 1) % c_N;
    endfunction

    function automatic void model_reset();
        q16.delete(); q10.delete();
        m_cnt = 0; m_sticky16 = 0; m_sticky10 = 0;
        m_swap = 0; m_shift = 0; m_round = 0;
    endfunction

    // Scoreboard: push on input transfer, pop/compare on output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready16) model_push(a_in);
            if (ov16 && out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++;
                    $display("FAIL sb16_unexpected got R_Out=%h required no output", r16);
                end else begin
                    e16 = q16.pop_front();
                    if ({r16, of16, ol16, sf16} !== {e16.data, e16.first, e16.last, e16.sat}) begin
                        failures++;
                        $display("FAIL sb16_output got data=%h f=%b l=%b s=%b required data=%h f=%b l=%b s=%b",
                                 r16, of16, ol16, sf16, e16.data, e16.first, e16.last, e16.sat);
                    end
                end
            end
            if (ov10 && out_ready) begin
                checks++;
                if (q10.size() == 0) begin
                    failures++;
                    $display("FAIL sb10_unexpected got R_Out=%h required no output", r10);
                end else begin
                    e10 = q10.pop_front();
                    if ({r10, of10, ol10, sf10} !== {e10.data[19:0], e10.first, e10.last, e10.sat}) begin
                        failures++;
                        $display("FAIL sb10_output got data=%h f=%b l=%b s=%b required data=%h f=%b l=%b s=%b",
                                 r10, of10, ol10, sf10, e10.data[19:0], e10.first, e10.last, e10.sat);
                    end
                end
            end
        end
    end

    // Present one sample and return one cycle after it is accepted (posedge+1).
    task automatic drive(input logic [31:0] a);
        int n;
        n = 0;
        a_in = a;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL drive_timeout got in_ready=0 required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic fill_frame(input bit rnd);
        while (m_cnt != 0) drive(rnd ? 32'($urandom) : 32'h0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        while ((q16.size() != 0 || q10.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (q16.size() != 0 || q10.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d/%0d required 0/0", q16.size(), q10.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({r16, ov16, of16, ol16, sf16} !== 36'h0) begin
            failures++;
            $display("FAIL reset16 got %h/%b%b%b%b required 0", r16, ov16, of16, ol16, sf16);
        end
        checks++;
        if ({r10, ov10, of10, ol10, sf10} !== 24'h0) begin
            failures++;
            $display("FAIL reset10 got %h/%b%b%b%b required 0", r10, ov10, of10, ol10, sf10);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready16, in_ready10} !== 2'b11) begin
            failures++;
            $display("FAIL reset_in_ready got %b%b required 11", in_ready16, in_ready10);
        end
    endtask

    task automatic test_truncate();
        swap = 1'b1; shift = 3'd6; round_en = 1'b0; out_ready = 1'b1;
        drive(32'h7FFF_8000);
        checks++;
        if ({ov16, r16} !== {1'b1, 32'h01FF_FE00}) begin
            failures++;
            $display("FAIL trunc16 got v=%b %h required v=1 01fffe00", ov16, r16);
        end
        checks++;
        if ({ov10, r10} !== {1'b1, 20'h7FE00}) begin
            failures++;
            $display("FAIL trunc10 got v=%b %h required v=1 7fe00", ov10, r10);
        end
        fill_frame(1'b1);
    endtask

    task automatic test_round();
        swap = 1'b1; shift = 3'd6; round_en = 1'b1;
        drive(32'h0020_FFDF);
        checks++;
        if (r16 !== 32'h0001_FFFF) begin
            failures++;
            $display("FAIL round16 got %h required 0001ffff", r16);
        end
        checks++;
        if (r10 !== 20'h007FF) begin
            failures++;
            $display("FAIL round10 got %h required 007ff", r10);
        end
        fill_frame(1'b1);
    endtask

    task automatic test_saturate();
        swap = 1'b0; shift = 3'd0; round_en = 1'b0;
        drive(32'h0300_FC00);
        checks++;
        if (r16 !== 32'h0300_FC00) begin
            failures++;
            $display("FAIL sat_pass16 got %h required 0300fc00", r16);
        end
        checks++;
        if (r10 !== 20'h7FE00) begin
            failures++;
            $display("FAIL sat_clip10 got %h required 7fe00", r10);
        end
        fill_frame(1'b0);
        checks++;
        if ({ol10, sf10, ol16, sf16} !== 4'b1110) begin
            failures++;
            $display("FAIL sat_frame_flag got l10=%b s10=%b l16=%b s16=%b required 1 1 1 0",
                     ol10, sf10, ol16, sf16);
        end
        drive(32'h0);
        fill_frame(1'b0);
        checks++;
        if ({ol10, sf10} !== 2'b10) begin
            failures++;
            $display("FAIL sat_clean_frame got l=%b s=%b required 1 0", ol10, sf10);
        end
    endtask

    task automatic test_back_to_back();
        longint t0;
        swap = 1'b1; shift = 3'd2; round_en = 1'b1;
        t0 = $time;
        for (int i = 0; i < c_N; i++) begin
            if (i == 10) shift = 3'd5;
            drive(32'($urandom));
            checks++;
            if ({ov16, of16, ol16} !== {1'b1, (i == 0), (i == c_N - 1)}) begin
                failures++;
                $display("FAIL b2b_flags idx=%0d got v=%b f=%b l=%b", i, ov16, of16, ol16);
            end
        end
        checks++;
        if (($time - t0) != 64'd640) begin
            failures++;
            $display("FAIL b2b_throughput got %0d ns required 640 ns", $time - t0);
        end
        shift = 3'd2;
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        swap = 1'b1; shift = 3'd0; round_en = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(32'h0011_0022);
        held = r16;
        a_in = 32'h0033_0044;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({in_ready16, ov16, r16} !== {1'b0, 1'b1, held}) begin
                failures++;
                $display("FAIL stall cyc=%0d got rdy=%b v=%b %h required rdy=0 v=1 %h",
                         k, in_ready16, ov16, r16, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({ov16, r16} !== {1'b1, 32'h0033_0044}) begin
            failures++;
            $display("FAIL stall_release got v=%b %h required v=1 00330044", ov16, r16);
        end
        drain();
        fill_frame(1'b1);
    endtask

    task automatic test_reset_midframe();
        swap = 1'b1; shift = 3'd0; round_en = 1'b0;
        for (int i = 0; i < 20; i++) drive(32'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({r16, ov16, of16, ol16, sf16, r10, ov10} !== 57'h0) begin
            failures++;
            $display("FAIL midreset_zero got %h v=%b %h v=%b required 0", r16, ov16, r10, ov10);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        swap = 1'b1; shift = 3'd7; round_en = 1'b0;
        drive(32'h7FFF_8000);
        checks++;
        if ({ov16, of16, r16} !== {1'b1, 1'b1, 32'h01FF_FE00}) begin
            failures++;
            $display("FAIL midreset_first got v=%b f=%b %h required v=1 f=1 01fffe00", ov16, of16, r16);
        end
        checks++;
        if ({of10, r10} !== {1'b1, 20'h7FE00}) begin
            failures++;
            $display("FAIL midreset_first10 got f=%b %h required f=1 7fe00", of10, r10);
        end
        for (int i = 0; i < 5; i++) drive(32'($urandom));
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_truncate();
        test_round();
        test_saturate();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
